div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 126 ++++++++++++
 tb/tb_div_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RISC-V div/divu/rem/remu.
// Takes one iteration per cycle; the result is valid for one cycle when done pulses.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       div_cntrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [5:0]       count;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] dividend_raw;
    logic [1:0]       op;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             q_bit;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // Magnitudes of the incoming operands; negating 0x80000000 yields 0x80000000,
    // which is exactly the unsigned magnitude we want.
    always_comb begin
        signed_op = ~div_cntrl[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // One restoring step: the quotient register doubles as the dividend shifter.
    always_comb begin
        shifted  = {part_rem[WIDTH-1:0], quo[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, divisor};
        q_bit    = ~diff[WIDTH+1];
        rem_next = q_bit ? diff[WIDTH:0] : shifted;
        quo_next = {quo[WIDTH-2:0], q_bit};
        q_final  = neg_q ? -quo_next : quo_next;
        r_final  = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    end

    // The signed overflow case (-2^31 / -1) falls out naturally: |a|/1 gives
    // 0x80000000 with no negation and a zero remainder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            part_rem     <= '0;
            quo          <= '0;
            divisor      <= '0;
            dividend_raw <= '0;
            op           <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_zero     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state        <= CALC;
                        busy         <= 1'b1;
                        count        <= '0;
                        part_rem     <= '0;
                        quo          <= a_mag;
                        divisor      <= b_mag;
                        dividend_raw <= a;
                        op           <= div_cntrl;
                        neg_q        <= a_neg ^ b_neg;
                        neg_r        <= a_neg;
                        div_zero     <= (b == '0);
                    end
                end
                CALC: begin
                    part_rem <= rem_next;
                    quo      <= quo_next;
                    count    <= count + 6'd1;
                    if (count == 6'(WIDTH - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        if (div_zero)
                            result <= op[1] ? dividend_raw : '1;
                        else
                            result <= op[1] ? r_final : q_final;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, back-to-back and reset
// sequences, and randomized operations checked against an arithmetic model.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  div_cntrl;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .div_cntrl (div_cntrl),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [1:0]  op;
        logic [31:0] expected;
        string       name;
    } vec_t;

    // RISC-V M semantics from plain signed/unsigned arithmetic.
    function automatic logic [31:0] refModel(input logic [31:0] x, input logic [31:0] y,
                                             input logic [1:0] c);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        longint             lx;
        longint             ly;
        longint             r;
        sx = x;
        sy = y;
        lx = sx;
        ly = sy;
        case (c)
            2'b00: begin
                if (y == 0) return 32'hFFFF_FFFF;
                r = lx / ly;
                return r[31:0];
            end
            2'b01: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            2'b10: begin
                if (y == 0) return x;
                r = lx % ly;
                return r[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called #1 after the accepting edge; counts edges until done (bounded).
    task automatic waitDone(input int change_at, input logic [31:0] na, input logic [31:0] nb,
                            input logic [1:0] nc, input logic nstart,
                            output int cycles, output int busy_cycles);
        cycles      = 1;
        busy_cycles = busy ? 1 : 0;
        while (done !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == change_at) begin
                a         = na;
                b         = nb;
                div_cntrl = nc;
                start     = nstart;
            end
            if (busy === 1'b1) busy_cycles++;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                                 input logic [1:0] op, input logic [31:0] expected,
                                 input string name);
        int cycles;
        int busy_cycles;
        @(negedge clk);
        a         = va;
        b         = vb;
        div_cntrl = op;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(6, $urandom, $urandom, 2'($urandom_range(3)), 1'b0, cycles, busy_cycles);
        checkOutput({name, "_latency"}, 32'(cycles), 32'd33);
        checkOutput({name, "_busycycles"}, 32'(busy_cycles), 32'd33);
        checkOutput({name, "_result"}, result, expected);
        @(posedge clk);
        #1;
        checkOutput({name, "_donepulse"}, {31'd0, done}, 32'd0);
        checkOutput({name, "_idlebusy"}, {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        int          cycles;
        int          busy_cycles;
        int          spurious;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rc;

        vecs[0]  = '{32'd100,       32'd7,         2'b01, 32'd14,        "divu_100_7"};
        vecs[1]  = '{32'hFFFF_FFF9, 32'd2,         2'b00, 32'hFFFF_FFFD, "div_m7_2"};
        vecs[2]  = '{32'hFFFF_FFF9, 32'd2,         2'b10, 32'hFFFF_FFFF, "rem_m7_2"};
        vecs[3]  = '{32'h1234_5678, 32'd0,         2'b00, 32'hFFFF_FFFF, "div_by0"};
        vecs[4]  = '{32'h1234_5678, 32'd0,         2'b10, 32'h1234_5678, "rem_by0"};
        vecs[5]  = '{32'h8000_0000, 32'd0,         2'b11, 32'h8000_0000, "remu_by0"};
        vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, "div_ovf"};
        vecs[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'd0,         "rem_ovf"};
        vecs[8]  = '{32'd7,         32'hFFFF_FFFE, 2'b00, 32'hFFFF_FFFD, "div_7_m2"};
        vecs[9]  = '{32'd7,         32'hFFFF_FFFE, 2'b10, 32'd1,         "rem_7_m2"};
        vecs[10] = '{32'hFFFF_FFFF, 32'd16,        2'b11, 32'd15,        "remu_max_16"};
        vecs[11] = '{32'hFFFF_FFFF, 32'd1,         2'b01, 32'hFFFF_FFFF, "divu_max_1"};

        start     = 1'b0;
        a         = '0;
        b         = '0;
        div_cntrl = '0;
        reset     = 1'b0;
        #1;
        reset = 1'b1;
        #3;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            applyStimulus(vecs[i].va, vecs[i].vb, vecs[i].op, vecs[i].expected, vecs[i].name);

        // Start held high: divu 9/3, then remu 9/4 accepted right after DONE.
        @(negedge clk);
        a         = 32'd9;
        b         = 32'd3;
        div_cntrl = 2'b01;
        start     = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("b2b_accept1", {31'd0, busy}, 32'd1);
        waitDone(5, 32'd9, 32'd4, 2'b11, 1'b1, cycles, busy_cycles);
        checkOutput("b2b_latency1", 32'(cycles), 32'd33);
        checkOutput("b2b_result1", result, 32'd3);
        @(posedge clk);
        #1;
        checkOutput("b2b_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("b2b_idle_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("b2b_accept2", {31'd0, busy}, 32'd1);
        waitDone(5, 32'd100, 32'd7, 2'b01, 1'b0, cycles, busy_cycles);
        checkOutput("b2b_latency2", 32'(cycles), 32'd33);
        checkOutput("b2b_result2", result, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("b2b_end_done", {31'd0, done}, 32'd0);

        // Reset at iteration 10 of divu 50/5.
        @(negedge clk);
        a         = 32'd50;
        b         = 32'd5;
        div_cntrl = 2'b01;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, done}, 32'd0);
        checkOutput("midreset_result", result, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) spurious++;
        end
        checkOutput("midreset_quiet", 32'(spurious), 32'd0);
        applyStimulus(32'd50, 32'd5, 2'b01, 32'd10, "after_reset");

        // Randomized operations, biased toward the special operand values.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(3))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'($urandom_range(200));
                default: ra = $urandom;
            endcase
            case ($urandom_range(5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(20));
                default: rb = $urandom >> $urandom_range(31);
            endcase
            rc = 2'($urandom_range(3));
            applyStimulus(ra, rb, rc, refModel(ra, rb, rc), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
